// File: rtl/hd_demux4_lane_recover.sv
// 1-to-4 time-division demultiplexer: recovers four parallel lanes from a
// SOF-marked beat stream and drives the slot select back to the upstream mux.
module hd_demux4_lane_recover #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic             CK,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  input  logic             SOF,
  output logic             SL0,
  output logic             SL1,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic             QV,
  output logic             ERR,
  output logic [CNTW-1:0]  FCNT
);

  typedef enum logic {HUNT, RUN} state_t;

  state_t           state;
  logic [1:0]       slot;
  logic [WIDTH-1:0] stg0, stg1, stg2;

  // Select bits come straight from the slot register.
  assign SL0 = slot[0];
  assign SL1 = slot[1];

  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      state <= HUNT;
      slot  <= 2'd0;
      stg0  <= '0;
      stg1  <= '0;
      stg2  <= '0;
      Q0    <= '0;
      Q1    <= '0;
      Q2    <= '0;
      Q3    <= '0;
      QV    <= 1'b0;
      ERR   <= 1'b0;
      FCNT  <= '0;
    end else begin
      QV  <= 1'b0;
      ERR <= 1'b0;
      if (DV) begin
        case (state)
          HUNT: begin
            if (SOF) begin
              stg0  <= D;
              slot  <= 2'd1;
              state <= RUN;
            end
          end
          RUN: begin
            if (SOF) begin
              // SOF anywhere but slot 0 drops the partial frame and resyncs.
              if (slot != 2'd0) ERR <= 1'b1;
              stg0 <= D;
              slot <= 2'd1;
            end else begin
              case (slot)
                2'd0: begin
                  ERR   <= 1'b1;
                  state <= HUNT;
                end
                2'd1: begin
                  stg1 <= D;
                  slot <= 2'd2;
                end
                2'd2: begin
                  stg2 <= D;
                  slot <= 2'd3;
                end
                default: begin
                  Q0   <= stg0;
                  Q1   <= stg1;
                  Q2   <= stg2;
                  Q3   <= D;
                  QV   <= 1'b1;
                  slot <= 2'd0;
                  if (FCNT != {CNTW{1'b1}}) FCNT <= FCNT + CNTW'(1);
                end
              endcase
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hd_demux4_lane_recover.sv
// Directed bench for hd_demux4_lane_recover; a second instance with CNTW=2
// shares the stimulus to exercise counter saturation.
module tb_hd_demux4_lane_recover;

  logic        CK = 1'b0;
  logic        R;
  logic [7:0]  D;
  logic        DV;
  logic        SOF;

  logic        SL0, SL1, QV, ERR;
  logic [7:0]  Q0, Q1, Q2, Q3;
  logic [15:0] FCNT;

  logic        s_SL0, s_SL1, s_QV, s_ERR;
  logic [7:0]  s_Q0, s_Q1, s_Q2, s_Q3;
  logic [1:0]  s_FCNT;

  int checks = 0;
  int errors = 0;

  hd_demux4_lane_recover #(.WIDTH(8), .CNTW(16)) dut (
    .CK(CK), .R(R), .D(D), .DV(DV), .SOF(SOF),
    .SL0(SL0), .SL1(SL1), .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
    .QV(QV), .ERR(ERR), .FCNT(FCNT)
  );

  hd_demux4_lane_recover #(.WIDTH(8), .CNTW(2)) dut_sat (
    .CK(CK), .R(R), .D(D), .DV(DV), .SOF(SOF),
    .SL0(s_SL0), .SL1(s_SL1), .Q0(s_Q0), .Q1(s_Q1), .Q2(s_Q2), .Q3(s_Q3),
    .QV(s_QV), .ERR(s_ERR), .FCNT(s_FCNT)
  );

  always #5 CK = ~CK;

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic dv, input logic sof, input logic [7:0] d);
    DV  = dv;
    SOF = sof;
    D   = d;
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset();
    R = 1'b1;
    DV = 1'b0; SOF = 1'b0; D = 8'h00;
    @(posedge CK); #1;
    @(posedge CK); #1;
    R = 1'b0;
    @(posedge CK); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({SL1, SL0, QV, ERR} !== 4'b0000 || {Q3, Q2, Q1, Q0} !== 32'h0 || FCNT !== 16'd0) begin
      errors++;
      $display("FAIL reset_state got sl=%b%b qv=%b err=%b q=%h fcnt=%0d exp all zero",
               SL1, SL0, QV, ERR, {Q3, Q2, Q1, Q0}, FCNT);
    end
  endtask

  task automatic test_basic();
    logic [1:0] exp_sl [4];
    logic [7:0] beats [4];
    exp_sl = '{2'd1, 2'd2, 2'd3, 2'd0};
    beats  = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, beats[i]);
      checks++;
      if ({SL1, SL0} !== exp_sl[i]) begin
        errors++;
        $display("FAIL basic_slot%0d got %b exp %b", i, {SL1, SL0}, exp_sl[i]);
      end
    end
    checks++;
    if ({Q3, Q2, Q1, Q0} !== 32'h44332211 || QV !== 1'b1 || FCNT !== 16'd1) begin
      errors++;
      $display("FAIL basic_frame got q=%h qv=%b fcnt=%0d exp q=44332211 qv=1 fcnt=1",
               {Q3, Q2, Q1, Q0}, QV, FCNT);
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (QV !== 1'b0 || {Q3, Q2, Q1, Q0} !== 32'h44332211) begin
      errors++;
      $display("FAIL basic_qv_pulse got qv=%b q=%h exp qv=0 q=44332211", QV, {Q3, Q2, Q1, Q0});
    end
  endtask

  task automatic test_gapped();
    do_reset();
    step(1'b1, 1'b1, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'hEE);
      checks++;
      if ({SL1, SL0} !== 2'd2 || QV !== 1'b0) begin
        errors++;
        $display("FAIL gap_hold%0d got sl=%b qv=%b exp sl=10 qv=0", i, {SL1, SL0}, QV);
      end
    end
    step(1'b1, 1'b0, 8'h33);
    checks++;
    if (QV !== 1'b0 || {SL1, SL0} !== 2'd3) begin
      errors++;
      $display("FAIL gap_beat3 got qv=%b sl=%b exp qv=0 sl=11", QV, {SL1, SL0});
    end
    step(1'b1, 1'b0, 8'h44);
    checks++;
    if ({Q3, Q2, Q1, Q0} !== 32'h44332211 || QV !== 1'b1 || FCNT !== 16'd1) begin
      errors++;
      $display("FAIL gap_frame got q=%h qv=%b fcnt=%0d exp q=44332211 qv=1 fcnt=1",
               {Q3, Q2, Q1, Q0}, QV, FCNT);
    end
  endtask

  task automatic test_early_sof();
    do_reset();
    step(1'b1, 1'b1, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b1, 8'hAA);
    checks++;
    if (ERR !== 1'b1 || QV !== 1'b0 || {SL1, SL0} !== 2'd1 || {Q3, Q2, Q1, Q0} !== 32'h0) begin
      errors++;
      $display("FAIL early_sof_err got err=%b qv=%b sl=%b q=%h exp err=1 qv=0 sl=01 q=0",
               ERR, QV, {SL1, SL0}, {Q3, Q2, Q1, Q0});
    end
    step(1'b1, 1'b0, 8'hBB);
    checks++;
    if (ERR !== 1'b0) begin
      errors++;
      $display("FAIL early_sof_err_pulse got %b exp 0", ERR);
    end
    step(1'b1, 1'b0, 8'hCC);
    step(1'b1, 1'b0, 8'hDD);
    checks++;
    if ({Q3, Q2, Q1, Q0} !== 32'hDDCCBBAA || QV !== 1'b1 || ERR !== 1'b0 || FCNT !== 16'd1) begin
      errors++;
      $display("FAIL early_sof_frame got q=%h qv=%b err=%b fcnt=%0d exp q=ddccbbaa qv=1 err=0 fcnt=1",
               {Q3, Q2, Q1, Q0}, QV, ERR, FCNT);
    end
  endtask

  task automatic test_missing_sof();
    do_reset();
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b0, 8'h02);
    step(1'b1, 1'b0, 8'h03);
    step(1'b1, 1'b0, 8'h04);
    step(1'b1, 1'b0, 8'h55);
    checks++;
    if (ERR !== 1'b1 || QV !== 1'b0 || {SL1, SL0} !== 2'd0) begin
      errors++;
      $display("FAIL missing_sof_err got err=%b qv=%b sl=%b exp err=1 qv=0 sl=00", ERR, QV, {SL1, SL0});
    end
    step(1'b1, 1'b0, 8'h66);
    checks++;
    if (ERR !== 1'b0 || {SL1, SL0} !== 2'd0) begin
      errors++;
      $display("FAIL hunt_drop got err=%b sl=%b exp err=0 sl=00", ERR, {SL1, SL0});
    end
    step(1'b1, 1'b1, 8'h71);
    step(1'b1, 1'b0, 8'h72);
    step(1'b1, 1'b0, 8'h73);
    step(1'b1, 1'b0, 8'h74);
    checks++;
    if ({Q3, Q2, Q1, Q0} !== 32'h74737271 || QV !== 1'b1 || FCNT !== 16'd2) begin
      errors++;
      $display("FAIL missing_sof_recover got q=%h qv=%b fcnt=%0d exp q=74737271 qv=1 fcnt=2",
               {Q3, Q2, Q1, Q0}, QV, FCNT);
    end
  endtask

  task automatic test_back_to_back_sat();
    logic [1:0] exp_sat [5];
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int b = 0; b < 4; b++) begin
        step(1'b1, b == 0, 8'((f << 4) | b));
        checks++;
        if (s_QV !== (b == 3) || QV !== (b == 3)) begin
          errors++;
          $display("FAIL b2b_qv f%0d b%0d got qv=%b sat_qv=%b exp %b", f, b, QV, s_QV, b == 3);
        end
      end
      checks++;
      if (s_FCNT !== exp_sat[f] || FCNT !== 16'(f + 1)) begin
        errors++;
        $display("FAIL sat_fcnt f%0d got sat=%0d wide=%0d exp sat=%0d wide=%0d",
                 f, s_FCNT, FCNT, exp_sat[f], f + 1);
      end
    end
    checks++;
    if ({s_Q3, s_Q2, s_Q1, s_Q0} !== 32'h43424140) begin
      errors++;
      $display("FAIL sat_last_frame got %h exp 43424140", {s_Q3, s_Q2, s_Q1, s_Q0});
    end
  endtask

  task automatic test_reset_midrun();
    // Q and FCNT are non-zero from the previous test.
    step(1'b1, 1'b1, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    checks++;
    if ({SL1, SL0} !== 2'd2) begin
      errors++;
      $display("FAIL midrun_pre got sl=%b exp 10", {SL1, SL0});
    end
    R = 1'b1;
    #1;
    checks++;
    if ({SL1, SL0, QV, ERR} !== 4'b0000 || {Q3, Q2, Q1, Q0} !== 32'h0 || FCNT !== 16'd0 ||
        s_FCNT !== 2'd0) begin
      errors++;
      $display("FAIL midrun_reset got sl=%b%b qv=%b err=%b q=%h fcnt=%0d exp all zero",
               SL1, SL0, QV, ERR, {Q3, Q2, Q1, Q0}, FCNT);
    end
    @(posedge CK); #1;
    R = 1'b0;
    step(1'b1, 1'b0, 8'h77);
    checks++;
    if ({SL1, SL0} !== 2'd0 || ERR !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_hunt got sl=%b err=%b exp sl=00 err=0", {SL1, SL0}, ERR);
    end
    step(1'b1, 1'b1, 8'h88);
    checks++;
    if ({SL1, SL0} !== 2'd1) begin
      errors++;
      $display("FAIL post_reset_sof got sl=%b exp 01", {SL1, SL0});
    end
  endtask

  // QV and ERR must never coincide.
  always @(negedge CK) begin
    if (!R && QV && ERR) begin
      errors++;
      $display("FAIL qv_err_overlap got qv=1 err=1 exp not both");
    end
  end

  initial begin
    R = 1'b1; DV = 1'b0; SOF = 1'b0; D = 8'h00;
    test_reset();
    test_basic();
    test_gapped();
    test_early_sof();
    test_missing_sof();
    test_back_to_back_sat();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
